// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage with valid/ready handshake, halt (freeze) and flush (kill).
// Define EX_MEM_SKID_EN for a two-entry main+skid stage whose in_ready is registered.
module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] ex_wd,
    input  logic               ex_wreg,
    input  logic [DATA_W-1:0]  ex_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] mem_wd,
    output logic               mem_wreg,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [1:0]         occupancy
);

    // Main entry: the one presented to MEM.
    logic               vld_p0;
    logic [RADDR_W-1:0] wd_p0;
    logic               wreg_p0;
    logic [DATA_W-1:0]  wdata_p0;

    logic               vld_p0_nx;
    logic [RADDR_W-1:0] wd_p0_nx;
    logic               wreg_p0_nx;
    logic [DATA_W-1:0]  wdata_p0_nx;

    logic acc;
    logic rel;

    // in_ready already carries !halt; flush must still block capture.
    assign acc = in_valid && in_ready && !flush;
    assign rel = vld_p0 && out_ready && !halt;

`ifdef EX_MEM_SKID_EN
    // Skid entry: catches the beat that was in flight when MEM stalled.
    logic               vld_p1;
    logic [RADDR_W-1:0] wd_p1;
    logic               wreg_p1;
    logic [DATA_W-1:0]  wdata_p1;

    logic               vld_p1_nx;
    logic [RADDR_W-1:0] wd_p1_nx;
    logic               wreg_p1_nx;
    logic [DATA_W-1:0]  wdata_p1_nx;

    logic ready_q;

    always_comb begin
        vld_p0_nx   = vld_p0;
        wd_p0_nx    = wd_p0;
        wreg_p0_nx  = wreg_p0;
        wdata_p0_nx = wdata_p0;
        vld_p1_nx   = vld_p1;
        wd_p1_nx    = wd_p1;
        wreg_p1_nx  = wreg_p1;
        wdata_p1_nx = wdata_p1;
        if (flush) begin
            vld_p0_nx = 1'b0;
            vld_p1_nx = 1'b0;
        end else begin
            if (rel) begin
                if (vld_p1) begin
                    vld_p0_nx   = 1'b1;
                    wd_p0_nx    = wd_p1;
                    wreg_p0_nx  = wreg_p1;
                    wdata_p0_nx = wdata_p1;
                    vld_p1_nx   = 1'b0;
                end else begin
                    vld_p0_nx = 1'b0;
                end
            end
            if (acc) begin
                if (!vld_p0_nx) begin
                    vld_p0_nx   = 1'b1;
                    wd_p0_nx    = ex_wd;
                    wreg_p0_nx  = ex_wreg;
                    wdata_p0_nx = ex_wdata;
                end else begin
                    vld_p1_nx   = 1'b1;
                    wd_p1_nx    = ex_wd;
                    wreg_p1_nx  = ex_wreg;
                    wdata_p1_nx = ex_wdata;
                end
            end
        end
    end

    // Skid register stage boundary; ready_q mirrors "skid will be empty".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            wd_p1    <= '0;
            wreg_p1  <= 1'b0;
            wdata_p1 <= '0;
            ready_q  <= 1'b0;
        end else begin
            vld_p1   <= vld_p1_nx;
            wd_p1    <= wd_p1_nx;
            wreg_p1  <= wreg_p1_nx;
            wdata_p1 <= wdata_p1_nx;
            ready_q  <= !vld_p1_nx;
        end
    end

    assign in_ready  = ready_q && !halt;
    assign occupancy = {vld_p0 & vld_p1, vld_p0 ^ vld_p1};
`else
    // Held low through reset and until the first edge after release.
    logic rst_done;

    always_comb begin
        vld_p0_nx   = vld_p0;
        wd_p0_nx    = wd_p0;
        wreg_p0_nx  = wreg_p0;
        wdata_p0_nx = wdata_p0;
        if (flush) begin
            vld_p0_nx = 1'b0;
        end else if (acc) begin
            vld_p0_nx   = 1'b1;
            wd_p0_nx    = ex_wd;
            wreg_p0_nx  = ex_wreg;
            wdata_p0_nx = ex_wdata;
        end else if (rel) begin
            vld_p0_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    assign in_ready  = rst_done && (!vld_p0 || out_ready) && !halt;
    assign occupancy = {1'b0, vld_p0};
`endif

    // Main register stage boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0   <= 1'b0;
            wd_p0    <= '0;
            wreg_p0  <= 1'b0;
            wdata_p0 <= '0;
        end else begin
            vld_p0   <= vld_p0_nx;
            wd_p0    <= wd_p0_nx;
            wreg_p0  <= wreg_p0_nx;
            wdata_p0 <= wdata_p0_nx;
        end
    end

    // Stale payload never leaks to MEM: everything reads zero without a valid entry.
    assign out_valid = vld_p0;
    assign mem_wd    = vld_p0 ? wd_p0    : '0;
    assign mem_wreg  = vld_p0 && wreg_p0;
    assign mem_wdata = vld_p0 ? wdata_p0 : '0;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: directed scenarios plus randomized valid/ready/halt/flush traffic.
module tb_ex_mem_pipe;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
`ifdef EX_MEM_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               halt = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [RADDR_W-1:0] ex_wd = '0;
    logic               ex_wreg = 1'b0;
    logic [DATA_W-1:0]  ex_wdata = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [RADDR_W-1:0] mem_wd;
    logic               mem_wreg;
    logic [DATA_W-1:0]  mem_wdata;
    logic [1:0]         occupancy;

    ex_mem_pipe #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst), .halt(halt), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
    } ent_t;

    ent_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   popped = 0;
    bit   up = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue bounded by DEPTH, evaluated mid-cycle.
    always @(negedge clk) begin
        ent_t e;
        bit   exp_rdy;
        if (!rst) begin
            q.delete();
            up = 1'b0;
        end
`ifdef EX_MEM_SKID_EN
        exp_rdy = up && !halt && (q.size() < 2);
`else
        exp_rdy = up && !halt && (q.size() == 0 || out_ready);
`endif
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("mem_wd", 64'(mem_wd), 64'(q[0].wd));
            chk("mem_wreg", 64'(mem_wreg), 64'(q[0].wreg));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
        end else begin
            chk("idle_wd", 64'(mem_wd), 64'd0);
            chk("idle_wreg", 64'(mem_wreg), 64'd0);
            chk("idle_wdata", 64'(mem_wdata), 64'd0);
        end
        if (rst) begin
            if (flush) begin
                q.delete();
            end else if (!halt) begin
                if (q.size() != 0 && out_ready) begin
                    void'(q.pop_front());
                    popped++;
                end
                if (in_valid && exp_rdy) begin
                    e.wd    = ex_wd;
                    e.wreg  = ex_wreg;
                    e.wdata = ex_wdata;
                    q.push_back(e);
                    pushed++;
                end
            end
            up = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RADDR_W-1:0] wd, input logic wreg, input logic [DATA_W-1:0] wdata);
        in_valid = v;
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = wdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_push, start_pop, cyc;
        // Power-on reset, released mid-cycle.
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        #2 rst = 1'b1;
        #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        tick();
        chk("in_ready_rise", 64'(in_ready), 64'd1);

        // Single entry through an empty stage.
        out_ready = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 32'hDEADBEEF);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_mem_wd", 64'(mem_wd), 64'd5);
        chk("lat_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("lat_occupancy", 64'(occupancy), 64'd1);
        tick();
        chk("lat_drained", 64'(out_valid), 64'd0);

        // Back-pressure fill.
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 32'h11);
        tick();
`ifdef EX_MEM_SKID_EN
        drive(1'b1, 5'd2, 1'b1, 32'h22);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("skid_occupancy", 64'(occupancy), 64'd2);
        chk("skid_in_ready", 64'(in_ready), 64'd0);
        chk("skid_head", 64'(mem_wdata), 64'h11);
        out_ready = 1'b1;
        tick();
        chk("skid_second", 64'(mem_wdata), 64'h22);
        tick();
        chk("skid_empty", 64'(out_valid), 64'd0);
`else
        drive(1'b0, '0, 1'b0, '0);
        chk("full_occupancy", 64'(occupancy), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(mem_wdata), 64'h11);
        out_ready = 1'b1;
        tick();
        chk("full_drained", 64'(out_valid), 64'd0);
`endif

        // Halt freezes a held entry even with MEM ready.
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 32'h33);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        halt = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_wdata", 64'(mem_wdata), 64'h33);
            chk("halt_occupancy", 64'(occupancy), 64'd1);
            chk("halt_in_ready", 64'(in_ready), 64'd0);
        end
        halt = 1'b0;
        tick();
        chk("halt_release", 64'(occupancy), 64'd0);

        // Flush beats halt and a simultaneous input.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 5'(i + 4), 1'b1, 32'(32'h44 + 32'h11 * i));
            tick();
        end
        chk("preflush_occupancy", 64'(occupancy), 64'(DEPTH));
        flush = 1'b1;
        halt = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 32'h99);
        tick();
        flush = 1'b0;
        halt = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_wreg", 64'(mem_wreg), 64'd0);
        chk("flush_wdata", 64'(mem_wdata), 64'd0);

        // Asynchronous reset mid-stream, away from any edge.
        drive(1'b1, 5'd7, 1'b1, 32'h77);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_wd", 64'(mem_wd), 64'd0);
        chk("arst_wreg", 64'(mem_wreg), 64'd0);
        chk("arst_wdata", 64'(mem_wdata), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) tick();
        drive(1'b0, '0, 1'b0, '0);
        #2 rst = 1'b1;
        tick();
        chk("arst_in_ready_rise", 64'(in_ready), 64'd1);

        // 100-entry random valid/ready stream.
        start_push = pushed;
        start_pop  = popped;
        cyc = 0;
        while ((pushed - start_push) < 100 && cyc < 5000) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), 32'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        chk("stream_accepts", 64'(pushed - start_push), 64'd100);
        drive(1'b0, '0, 1'b0, '0);
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("stream_drain", 64'(q.size()), 64'd0);
        chk("stream_delivered", 64'(popped - start_pop), 64'd100);

        // Random traffic with occasional halt and flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), 32'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            halt      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        halt  = 1'b0;
        flush = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
